// File: rtl/ins_fetch_unit.sv
// Instruction-fetch front end: walks the PC, reads opcode plus 0-2
// extension words from ROM and holds the instruction until the decoder takes it.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   rom_req/rom_addr          ROM read request and word address (= pc)
//   rom_ack/rom_data          ROM read completion and data
//   Ins_load/Ins_addr         instruction valid and opcode word to decoder
//   ext_word1/2, ext_count    extension words and their count
//   ins_pc                    address of the presented opcode word
//   dec_ready                 decoder accept
//   branch_en/branch_target   one-cycle redirect request and target
//   halt                      stop fetching at the next instruction boundary
//   pc, busy                  current fetch address, not-halted flag
module ins_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [15:0]       rom_data,
    output logic              Ins_load,
    output logic [15:0]       Ins_addr,
    output logic [15:0]       ext_word1,
    output logic [15:0]       ext_word2,
    output logic [1:0]        ext_count,
    output logic [ADDR_W-1:0] ins_pc,
    input  logic              dec_ready,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic              busy
);

    typedef enum logic [2:0] {
        FETCH_OP,
        FETCH_EXT1,
        FETCH_EXT2,
        ISSUE,
        HALTED
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] ins_pc_q;
    logic [15:0]       ins_q;
    logic [15:0]       ext1_q;
    logic [15:0]       ext2_q;
    logic [1:0]        cnt_q;

    logic [1:0]        n_op;
    logic [ADDR_W-1:0] pc_inc;

    // Byte-count field: 00/01 carry no extension, 10 one word, 11 two.
    always_comb begin
        n_op = 2'd0;
        if (rom_data[13]) begin
            n_op = rom_data[12] ? 2'd2 : 2'd1;
        end
    end

    // Wraps modulo 2^ADDR_W.
    assign pc_inc = pc_q + ADDR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH_OP;
            pc_q     <= RESET_PC;
            ins_pc_q <= '0;
            ins_q    <= '0;
            ext1_q   <= '0;
            ext2_q   <= '0;
            cnt_q    <= '0;
        end else if (branch_en) begin
            // Redirect wins everywhere; any same-cycle ack is dropped.
            pc_q <= branch_target;
            if (state_q != HALTED) begin
                state_q <= FETCH_OP;
            end
        end else begin
            unique case (state_q)
                FETCH_OP: begin
                    if (halt) begin
                        state_q <= HALTED;
                    end else if (rom_ack) begin
                        ins_q    <= rom_data;
                        ins_pc_q <= pc_q;
                        pc_q     <= pc_inc;
                        ext1_q   <= '0;
                        ext2_q   <= '0;
                        cnt_q    <= n_op;
                        state_q  <= (n_op == 2'd0) ? ISSUE : FETCH_EXT1;
                    end
                end
                FETCH_EXT1: begin
                    if (rom_ack) begin
                        ext1_q  <= rom_data;
                        pc_q    <= pc_inc;
                        state_q <= (cnt_q == 2'd2) ? FETCH_EXT2 : ISSUE;
                    end
                end
                FETCH_EXT2: begin
                    if (rom_ack) begin
                        ext2_q  <= rom_data;
                        pc_q    <= pc_inc;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (dec_ready) begin
                        state_q <= FETCH_OP;
                    end
                end
                HALTED: begin
                    if (!halt) begin
                        state_q <= FETCH_OP;
                    end
                end
                default: state_q <= FETCH_OP;
            endcase
        end
    end

    // rst gating makes the request drop the moment reset is asserted.
    assign rom_req   = !rst && (((state_q == FETCH_OP) && !halt) ||
                                (state_q == FETCH_EXT1) ||
                                (state_q == FETCH_EXT2));
    assign rom_addr  = pc_q;
    assign pc        = pc_q;
    assign Ins_load  = (state_q == ISSUE);
    assign Ins_addr  = ins_q;
    assign ext_word1 = ext1_q;
    assign ext_word2 = ext2_q;
    assign ext_count = cnt_q;
    assign ins_pc    = ins_pc_q;
    assign busy      = (state_q != HALTED);

endmodule

// File: doc/ins_fetch_unit.md
Name: ins_fetch_unit

Overview:
- Instruction-fetch front end of the 16-bit CPU, and the producer side of the instruction-decoder interface.
- Walks the program counter and reads words from instruction ROM over a req/ack handshake.
- Uses the byte-count field (bits [13:12]) of each opcode word to fetch 0–2 extension words.
- Presents the complete instruction to the decoder with Ins_load held until accepted; handles branch redirect and halt.

Parameters:
- ADDR_W, 16, width of PC and ROM address
- RESET_PC, 16'h0000, PC value loaded on reset

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- rom_req  output  1  ROM read request; held with rom_addr stable until rom_ack
- rom_addr  output  ADDR_W  ROM word address (= pc)
- rom_ack  input  1  ROM read complete; rom_data valid this cycle
- rom_data  input  16  ROM read data
- Ins_load  output  1  instruction valid to decoder
- Ins_addr  output  16  opcode word presented to decoder
- ext_word1  output  16  first extension word (0 if none)
- ext_word2  output  16  second extension word (0 if none)
- ext_count  output  2  number of valid extension words (0..2)
- ins_pc  output  ADDR_W  address of the presented opcode word
- dec_ready  input  1  decoder accepts instruction when Ins_load & dec_ready
- branch_en  input  1  redirect request, one-cycle pulse
- branch_target  input  ADDR_W  redirect address
- halt  input  1  level; stop issuing ROM requests
- pc  output  ADDR_W  current fetch address
- busy  output  1  high in every state except HALTED

Behaviour:
- States: FETCH_OP, FETCH_EXT1, FETCH_EXT2, ISSUE, HALTED.
- All outputs are Moore outputs, decoded from registered state and registers.
- rom_req = 1 in FETCH_OP (only when halt = 0), FETCH_EXT1 and FETCH_EXT2.
- Ins_load = 1 only in ISSUE.
- Reset (async): state FETCH_OP, pc = RESET_PC; Ins_addr, ext_word1/2, ext_count and ins_pc = 0.
- Consequence of reset: rom_req rises in the first cycle after rst falls if halt = 0.
- FETCH_OP with halt = 1 -> HALTED, no request issued.
- FETCH_OP on rom_ack:
  - capture Ins_addr = rom_data and ins_pc = pc; pc <= pc + 1.
  - clear ext words.
  - decode n from rom_data[13:12]: 00/01 -> n = 0, 10 -> n = 1, 11 -> n = 2; ext_count <= n.
  - next state: n = 0 -> ISSUE, otherwise -> FETCH_EXT1.
- FETCH_EXT1 on ack: ext_word1 <= rom_data, pc <= pc + 1; go to FETCH_EXT2 if ext_count = 2, else ISSUE.
- FETCH_EXT2 on ack: ext_word2 <= rom_data, pc <= pc + 1 -> ISSUE.
- Without rom_ack, every fetch state holds: rom_addr stable, no pc change. Wait states are unbounded.
- ISSUE: hold Ins_addr, ext words, ext_count and ins_pc stable. On Ins_load & dec_ready -> FETCH_OP next cycle.
- Minimum throughput with a zero-wait ROM: 2 cycles per 1-word instruction, 4 per 3-word.
- HALTED: rom_req = 0, busy = 0. Return to FETCH_OP when halt = 0.
- pc arithmetic is modulo 2^ADDR_W: 16'hFFFF + 1 -> 16'h0000, with no flag.
- branch_en has highest priority, in any state: pc <= branch_target next cycle, and the state moves as follows:
  - in a fetch state: -> FETCH_OP; any rom_data acked in the same cycle is discarded. Request withdrawal mid-handshake is permitted by the ROM protocol.
  - in ISSUE without a same-cycle transfer: the instruction is flushed, Ins_load drops next cycle, -> FETCH_OP.
  - in ISSUE with a same-cycle transfer: the instruction counts as delivered, -> FETCH_OP at the target.
  - in HALTED: pc updated, stay HALTED.
- halt is honoured only at instruction boundaries (FETCH_OP entry); a multi-word fetch in progress completes and issues first.
- Simultaneous branch_en and halt: the branch updates pc; halt then takes effect from FETCH_OP on the following cycle.
- rst asserted mid-handshake: rom_req drops immediately (async); any ROM ack that follows is ignored.

Test Plan:
- Reset, zero-wait ROM, ROM[0] = 16'h4123 (n = 0), dec_ready = 1 -> cycle 1: rom_req, rom_addr = 0; cycle 2: Ins_load = 1, Ins_addr = 16'h4123, ext_count = 0, ins_pc = 0; cycle 3: rom_addr = 1.
- ROM[4] = 16'h3A00 (n = 2), ROM[5] = 16'hBEEF, ROM[6] = 16'h1234 -> Ins_load with ext_word1 = BEEF, ext_word2 = 1234, ext_count = 2, ins_pc = 4; next fetch at 7.
- dec_ready low for 5 cycles during ISSUE -> Ins_load and all fields stable for 5 cycles, pc unchanged, rom_req = 0; transfer on 6th cycle.
- ROM ack delayed 3 cycles per word -> rom_addr stable while waiting; correct words captured; pc advances exactly once per ack.
- branch_en pulse with target 16'h0100 while in FETCH_EXT1 with ack in the same cycle -> ext data discarded, no Ins_load for the partial instruction, next rom_addr = 0100.
- pc = 16'hFFFF with a 1-word instruction -> issued with ins_pc = FFFF; next rom_addr = 0000.
- halt raised during a 3-word fetch -> instruction completes and issues, then HALTED (rom_req = 0, busy = 0).
- halt released -> fetch resumes at the saved pc.
